// File: rtl/fp_exp_unit_pipe.sv
// Two-stage exponent datapath for FP multiply/divide: combines biased exponents,
// applies the normalisation adjust and classifies special/zero/overflow/underflow results.
module fp_exp_unit_pipe #(
  parameter int EXP_W = 8,
  parameter int BIAS  = (1 << (EXP_W - 1)) - 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             adj,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic             ovf,
  output logic             unf,
  output logic             zero,
  output logic             special,
  output logic [TAG_W-1:0] tag_out
);

  // Two guard bits keep the intermediate sum exact for every input combination.
  localparam int SW = EXP_W + 2;

  localparam logic [EXP_W-1:0]     EXP_MAX = '1;
  localparam logic signed [SW-1:0] BIAS_S  = SW'(BIAS);
  localparam logic signed [SW-1:0] OVF_S   = SW'((1 << EXP_W) - 1);
  localparam logic signed [SW-1:0] ZERO_S  = '0;

  typedef enum logic [2:0] {
    RES_NORMAL,
    RES_SPECIAL,
    RES_ZERO,
    RES_OVF,
    RES_UNF
  } res_cls_e;

  typedef struct packed {
    logic [SW-1:0]    sum;
    logic             a_max;
    logic             b_max;
    logic             a_zero;
    logic             b_zero;
    logic             mode;
    logic [TAG_W-1:0] tag;
  } s1_t;

  // ---------------------------------------------------------------------------
  // Handshake: each stage advances when it is empty or its successor drains.
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // ---------------------------------------------------------------------------
  // Stage 1: exponent arithmetic and operand classification.
  // ---------------------------------------------------------------------------
  s1_t                  s1_d;
  s1_t                  s1_q;
  logic signed [SW-1:0] ea;
  logic signed [SW-1:0] eb;
  logic signed [SW-1:0] ead;
  logic signed [SW-1:0] sum_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ea    = $signed({2'b00, exp_a});
    eb    = $signed({2'b00, exp_b});
    ead   = $signed({{(SW - 1){1'b0}}, adj});
    sum_d = ZERO_S;
    if (mode) begin
      sum_d = ea - eb + BIAS_S - ead;
    end else begin
      sum_d = ea + eb - BIAS_S + ead;
    end

    s1_d        = '0;
    s1_d.sum    = sum_d;
    s1_d.a_max  = (exp_a == EXP_MAX);
    s1_d.b_max  = (exp_b == EXP_MAX);
    // Exponent 0 covers both true zeros and subnormals, which are flushed.
    s1_d.a_zero = (exp_a == '0);
    s1_d.b_zero = (exp_b == '0);
    s1_d.mode   = mode;
    s1_d.tag    = tag_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and stage ordering cannot race.
  // NOTE: payload registers are reset alongside the valids; the outputs must
  // read zero during reset and the cost here is a handful of flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: priority resolution into a single result class.
  // ---------------------------------------------------------------------------
  res_cls_e             cls;
  logic signed [SW-1:0] s1_sum;
  logic [EXP_W-1:0]     exp_d;

  assign s1_sum = $signed(s1_q.sum);

  always_comb begin
    cls = RES_NORMAL;
    // A zero divisor is special even with a zero dividend: 0/0 yields NaN.
    if (s1_q.a_max || s1_q.b_max || (s1_q.mode && s1_q.b_zero)) begin
      cls = RES_SPECIAL;
    end else if (s1_q.a_zero || (!s1_q.mode && s1_q.b_zero)) begin
      cls = RES_ZERO;
    end else if (s1_sum >= OVF_S) begin
      cls = RES_OVF;
    end else if (s1_sum <= ZERO_S) begin
      cls = RES_UNF;
    end
  end

  always_comb begin
    exp_d = s1_q.sum[EXP_W-1:0];
    case (cls)
      RES_SPECIAL, RES_OVF: exp_d = EXP_MAX;
      RES_ZERO, RES_UNF:    exp_d = '0;
      default:              exp_d = s1_q.sum[EXP_W-1:0];
    endcase
  end

  // Result fields only change when a new op loads; they hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      exp_out   <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      zero      <= 1'b0;
      special   <= 1'b0;
      tag_out   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        exp_out <= exp_d;
        ovf     <= (cls == RES_OVF);
        unf     <= (cls == RES_UNF);
        zero    <= (cls == RES_ZERO);
        special <= (cls == RES_SPECIAL);
        tag_out <= s1_q.tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_exp_unit_pipe.sv
// Scoreboard bench for fp_exp_unit_pipe: directed corner cases, backpressure,
// mid-flight reset and randomized traffic against an integer reference model.
module tb_fp_exp_unit_pipe;

  localparam int EXP_W = 8;
  localparam int BIAS  = 127;
  localparam int TAG_W = 4;
  localparam int MAXE  = (1 << EXP_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic             adj;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] exp_out;
  logic             ovf;
  logic             unf;
  logic             zero;
  logic             special;
  logic [TAG_W-1:0] tag_out;

  fp_exp_unit_pipe #(.EXP_W(EXP_W), .BIAS(BIAS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .exp_a(exp_a), .exp_b(exp_b), .adj(adj), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .ovf(ovf), .unf(unf), .zero(zero), .special(special),
    .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [EXP_W-1:0] exp;
    logic             ovf;
    logic             unf;
    logic             zero;
    logic             special;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   accepts = 0;
  bit   check_lat = 1'b0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic and the classification rules in priority order.
  function automatic exp_t model(input bit m, input int a, input int b, input bit ad,
                                 input logic [TAG_W-1:0] tag);
    exp_t r;
    int   s;
    r.exp = '0; r.ovf = 1'b0; r.unf = 1'b0; r.zero = 1'b0; r.special = 1'b0;
    r.tag = tag; r.cyc = 0;
    s = m ? (a - b + BIAS - int'(ad)) : (a + b - BIAS + int'(ad));
    if (a == MAXE || b == MAXE || (m && b == 0)) begin
      r.special = 1'b1; r.exp = EXP_W'(MAXE);
    end else if (a == 0 || (!m && b == 0)) begin
      r.zero = 1'b1;
    end else if (s >= MAXE) begin
      r.ovf = 1'b1; r.exp = EXP_W'(MAXE);
    end else if (s <= 0) begin
      r.unf = 1'b1;
    end else begin
      r.exp = EXP_W'(s);
    end
    return r;
  endfunction

  task automatic issue(input bit m, input logic [EXP_W-1:0] a, input logic [EXP_W-1:0] b,
                       input bit ad, input logic [TAG_W-1:0] tag, input exp_t e);
    @(negedge clk);
    in_valid = 1'b1; mode = m; exp_a = a; exp_b = b; adj = ad; tag_in = tag;
    for (int g = 0; ; g++) begin
      #4;
      if (in_ready) begin
        e.cyc = cycle;
        sb.push_back(e);
        accepts++;
        break;
      end
      if (g >= 500) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Directed op with an explicitly stated expectation.
  task automatic dir(input bit m, input int a, input int b, input bit ad, input int ex,
                     input bit ov, input bit un, input bit ze, input bit sp,
                     input logic [TAG_W-1:0] tag);
    exp_t e;
    e.exp = EXP_W'(ex); e.ovf = ov; e.unf = un; e.zero = ze; e.special = sp;
    e.tag = tag; e.cyc = 0;
    issue(m, EXP_W'(a), EXP_W'(b), ad, tag, e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check("drain_left", sb.size(), 32'd0);
  endtask

  function automatic int pick();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return MAXE;
      2:       return 1;
      3:       return MAXE - 1;
      default: return int'($urandom_range(0, MAXE));
    endcase
  endfunction

  // Monitor: pops the scoreboard on each output handshake and checks hold stability.
  initial begin
    bit               hold = 1'b0;
    logic [EXP_W-1:0] h_exp;
    logic [3:0]       h_flags;
    logic [TAG_W-1:0] h_tag;
    exp_t             e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("hold_valid", out_valid, 32'd1);
        check("hold_exp", exp_out, h_exp);
        check("hold_flags", {ovf, unf, zero, special}, h_flags);
        check("hold_tag", tag_out, h_tag);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("exp_out", exp_out, e.exp);
          check("flags_ovf_unf_zero_spc", {ovf, unf, zero, special},
                {e.ovf, e.unf, e.zero, e.special});
          check("tag_out", tag_out, e.tag);
          if (check_lat) check("latency", cycle - e.cyc, 32'd2);
        end
      end
      hold = out_valid && !out_ready;
      h_exp = exp_out; h_flags = {ovf, unf, zero, special}; h_tag = tag_out;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; mode = 1'b0; exp_a = '0; exp_b = '0; adj = 1'b0; tag_in = '0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_exp_out", exp_out, 32'd0);
    check("rst_flags", {ovf, unf, zero, special}, 32'd0);
    check("rst_tag_out", tag_out, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corners: m, a, b, adj, exp_out, ovf, unf, zero, special, tag.
    check_lat = 1'b1;
    dir(0, 130, 125, 0, 128, 0, 0, 0, 0, 4'd0);
    dir(0, 130, 125, 1, 129, 0, 0, 0, 0, 4'd1);
    dir(0, 200, 200, 0, 255, 1, 0, 0, 0, 4'd2);
    dir(0,  60,  60, 0,   0, 0, 1, 0, 0, 4'd3);
    dir(0,  64,  63, 0,   0, 0, 1, 0, 0, 4'd4);
    dir(0,  64,  64, 0,   1, 0, 0, 0, 0, 4'd5);
    dir(0, 200, 181, 0, 254, 0, 0, 0, 0, 4'd6);
    dir(0, 200, 182, 0, 255, 1, 0, 0, 0, 4'd7);
    dir(1, 130, 125, 0, 132, 0, 0, 0, 0, 4'd8);
    dir(1,   1, 254, 1,   0, 0, 1, 0, 0, 4'd9);
    dir(1, 254,   1, 0, 255, 1, 0, 0, 0, 4'd10);
    dir(0, 255, 100, 0, 255, 0, 0, 0, 1, 4'd11);
    dir(0,   0, 255, 0, 255, 0, 0, 0, 1, 4'd12);
    dir(1,  10,   0, 0, 255, 0, 0, 0, 1, 4'd13);
    dir(1,   0,   0, 0, 255, 0, 0, 0, 1, 4'd14);
    dir(1,   0,  50, 0,   0, 0, 0, 1, 0, 4'd15);
    dir(0,   0, 100, 1,   0, 0, 0, 1, 0, 4'd3);
    idle();
    drain(20);
    check_lat = 1'b0;

    // Backpressure: five back-to-back ops against a stalled sink.
    @(negedge clk);
    out_ready = 1'b0;
    accepts = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          issue(0, EXP_W'(120 + i), EXP_W'(10 + i), 1'b0, TAG_W'(i),
                model(0, 120 + i, 10 + i, 0, TAG_W'(i)));
        end
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        #4;
        check("bp_accepts", accepts, 32'd2);
        check("bp_in_ready", in_ready, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain(20);
    check("bp_total_accepts", accepts, 32'd5);

    // Asynchronous reset with two ops in flight.
    @(negedge clk);
    out_ready = 1'b0;
    issue(0, 8'd140, 8'd130, 1'b0, 4'd6, model(0, 140, 130, 0, 4'd6));
    issue(1, 8'd140, 8'd130, 1'b0, 4'd7, model(1, 140, 130, 0, 4'd7));
    idle();
    #1;
    check("pre_rst_valid", out_valid, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("arst_out_valid", out_valid, 32'd0);
    check("arst_exp_out", exp_out, 32'd0);
    check("arst_flags", {ovf, unf, zero, special}, 32'd0);
    check("arst_tag_out", tag_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    check_lat = 1'b1;
    dir(1, 130, 125, 0, 132, 0, 0, 0, 0, 4'd9);
    idle();
    drain(20);
    check_lat = 1'b0;

    // Randomized traffic with random sink stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bit               m;
      bit               ad;
      int               a;
      int               b;
      logic [TAG_W-1:0] t;
      m = 1'($urandom_range(0, 1));
      ad = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      t = TAG_W'($urandom);
      issue(m, EXP_W'(a), EXP_W'(b), ad, t, model(m, a, b, ad, t));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
